wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Producer side of the register-file write port: merges two write-back sources into the single
//  we/waddr/wdata port. Source A is in-order ALU/EX results; source L is load data returning from memory.
//  Loads are buffered in a small FIFO. The block preserves write-after-write order per register and
//  drops writes to x0.
// PARAMETERS
//  DEPTH  4   load FIFO entries (power of 2, >=2)
//  AW     5   register address width (RegNumLog2)
//  DW     32  register data width (RegBus)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  alu_valid  in   1   ALU write request
//  alu_ready  out  1   ALU request accepted this cycle
//  alu_waddr  in   AW  ALU destination register
//  alu_wdata  in   DW  ALU result
//  ld_valid   in   1   load return request
//  ld_ready   out  1   load return accepted this cycle
//  ld_waddr   in   AW  load destination register
//  ld_wdata   in   DW  load data
//  we         out  1   regfile write enable (registered)
//  waddr      out  AW  regfile write address (registered)
//  wdata      out  DW  regfile write data (registered)
//  ld_pending out  1   FIFO non-empty (count != 0), for hazard logic
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): FIFO count/pointers=0; we=0, waddr=0, wdata=0. alu_ready=0 and
//    ld_ready=0 combinationally while rst=1; inputs ignored. Reset mid-operation discards all queued loads.
//  - Handshake: a transfer occurs when valid&&ready at posedge. Once asserted, valid holds with stable
//    addr/data until accepted.
//  - ld_ready = (count < DEPTH). An accepted load is pushed at the FIFO tail.
//  - alu_block = full || any valid FIFO entry has waddr==alu_waddr
//    || (ld_valid && ld_ready && ld_waddr==alu_waddr).
//    The comparison is skipped when alu_waddr==0. alu_ready = !alu_block.
//  - Same-cycle ALU/load arrival: the load is treated as older.
//  - Grant, one per cycle: ALU if alu_valid&&alu_ready; otherwise FIFO head if count!=0 (pop); otherwise idle.
//  - Output register, next posedge:
//    - we = granted && (granted waddr != 0);
//    - waddr/wdata = granted source values;
//    - when idle, we=0 and waddr/wdata hold their previous values.
//  - An x0 write still completes its handshake or pop but produces we=0.
//  - Latency:
//    - ALU accept -> we visible 1 cycle later.
//    - Load accept -> earliest we is 2 cycles later (push, then pop).
//  - Count update:
//    - push&&!pop: +1; pop&&!push: -1; push&&pop: unchanged (count is never 0 at a pop).
//    - No push when full: ld_ready=0, with no same-cycle look-ahead on pop.
//  - Pointers wrap modulo DEPTH. count width is $clog2(DEPTH)+1.
//  - Liveness: a blocked ALU request means the FIFO is popping, so the block clears within <=DEPTH
//    cycles once ld_valid stops matching.
// STRUCTURE
//  - Shared defines (defines.v): RegAddrBus, RegBus, RegNumLog2, WriteEnable/WriteDisable, ZeroWord.
//  - Sub-module wb_ld_fifo: DEPTH x (AW+DW) storage, push/pop, full/empty/count, per-entry waddr and
//    valid vector exported for the match compare.
//  - Top level: match compare, grant logic, output register.
// TESTING
//  1. Reset: drive rst=1 with alu_valid=ld_valid=1 -> alu_ready=ld_ready=0, we=0, waddr=0, wdata=0,
//     ld_pending=0.
//  2. ALU only: alu x5=0x1234 -> next cycle we=1, waddr=5, wdata=0x1234. Back-to-back x6, x7 gives one
//     write per cycle.
//  3. Load path, FIFO empty: ld x9=0xDEAD accepted at cycle t -> we=1, waddr=9 at t+2; ld_pending=1 during t+1.
//  4. WAW hazard: load x3=0xAAAA queued while ALU x3=0xBBBB is valid -> alu_ready=0 until the load drains;
//     writes appear in order x3=0xAAAA then x3=0xBBBB.
//  5. Full: with ALU streaming to distinct regs, push 4 loads -> ld_ready=0 on the 5th; ALU stalls
//     one cycle per pop; all 4 loads and the ALU writes emerge exactly once.
//  6. x0 and mid-op reset: ALU x0=0xFFFF -> handshake completes, we=0. Assert rst with 3 loads queued ->
//     no further we, count=0.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter_pkg
// Purpose : Shared widths, write-enable encodings and the grant encoding used
//           by the register-file write-back arbiter and its load FIFO.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package wb_write_arbiter_pkg;

    // Register-file geometry defaults
    localparam int REG_NUM_LOG2  = 5;
    localparam int REG_BUS_W     = 32;
    localparam int LD_FIFO_DEPTH = 4;

    // Write-enable encodings for the registered regfile strobe
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Which source owns the write port this cycle
    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LD   = 2'd2
    } grant_e;

endpackage : wb_write_arbiter_pkg
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter_if
// Purpose : Bundles the ALU request, load-return request and regfile write
//           port of the write-back arbiter.
// Ports   : alu_valid/alu_ready/alu_waddr/alu_wdata  - ALU write request
//           ld_valid/ld_ready/ld_waddr/ld_wdata      - load return request
//           we/waddr/wdata                           - regfile write port
//           ld_pending                               - load FIFO non-empty
//           modport master : request producer / regfile observer
//           modport slave  : the arbiter
// Rev     : 1.0  initial release
// ============================================================================
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int AW = REG_NUM_LOG2,
    parameter int DW = REG_BUS_W
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_waddr;
    logic [DW-1:0] alu_wdata;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_waddr;
    logic [DW-1:0] ld_wdata;

    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ld_pending;

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output ld_valid,  ld_waddr,  ld_wdata,
        input  alu_ready, ld_ready,
        input  we, waddr, wdata, ld_pending
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  ld_valid,  ld_waddr,  ld_wdata,
        output alu_ready, ld_ready,
        output we, waddr, wdata, ld_pending
    );

endinterface : wb_write_arbiter_if
`default_nettype wire

// File: rtl/wb_write_arbiter_ld_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_ld_fifo
// Purpose : Circular buffer of pending load write-backs. Exposes every
//           entry's destination address plus a per-entry valid vector so the
//           arbiter can detect write-after-write hazards against the ALU.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           i_push, i_waddr,
//           i_wdata               - enqueue at tail (ignored when full)
//           i_pop                 - dequeue head (ignored when empty)
//           o_head_waddr/wdata    - oldest entry
//           o_full, o_count       - occupancy
//           o_entry_waddr/valid   - per-slot address and occupancy
// Rev     : 1.0  initial release
// ============================================================================
module wb_ld_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH,
    parameter int AW    = REG_NUM_LOG2,
    parameter int DW    = REG_BUS_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [AW-1:0]            i_waddr,
    input  wire logic [DW-1:0]            i_wdata,
    input  wire logic                     i_pop,
    output logic      [AW-1:0]            o_head_waddr,
    output logic      [DW-1:0]            o_head_wdata,
    output logic                          o_full,
    output logic      [CW-1:0]            o_count,
    output logic      [DEPTH-1:0][AW-1:0] o_entry_waddr,
    output logic      [DEPTH-1:0]         o_entry_valid
);

    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_DEPTH);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && (r_count != '0);

    assign o_head_waddr = r_addr[r_rd_ptr];
    assign o_head_wdata = r_data[r_rd_ptr];

    // A slot holds live data when its distance from the read pointer
    // (modulo DEPTH) is below the occupancy count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] w_offset;
            assign w_offset          = PW'(gi) - r_rd_ptr;
            assign o_entry_waddr[gi] = r_addr[gi];
            assign o_entry_valid[gi] = ({1'b0, w_offset} < r_count);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the count/pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_waddr;
            r_data[r_wr_ptr] <= i_wdata;
        end
    end

endmodule : wb_ld_fifo
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter
// Purpose : Merges in-order ALU results and buffered load returns onto the
//           single regfile write port, keeping write-after-write order per
//           register and suppressing writes to x0.
// Ports   : clk   - rising-edge clock
//           rst   - synchronous active-high reset
//           bus   - wb_write_arbiter_if.slave (ALU/load requests, regfile
//                   write port, ld_pending)
// Rev     : 1.0  initial release
// ============================================================================
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH,
    parameter int AW    = REG_NUM_LOG2,
    parameter int DW    = REG_BUS_W,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wb_write_arbiter_if.slave bus
);

    logic [AW-1:0]            w_head_waddr;
    logic [DW-1:0]            w_head_wdata;
    logic                     w_full;
    logic [CW-1:0]            w_count;
    logic [DEPTH-1:0][AW-1:0] w_entry_waddr;
    logic [DEPTH-1:0]         w_entry_valid;

    logic   w_ld_ready;
    logic   w_ld_push;
    logic   w_fifo_hit;
    logic   w_arrival_hit;
    logic   w_alu_block;
    logic   w_alu_ready;
    logic   w_alu_fire;
    logic   w_ld_pop;
    grant_e w_grant;

    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    wb_ld_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ld_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_ld_push),
        .i_waddr       (bus.ld_waddr),
        .i_wdata       (bus.ld_wdata),
        .i_pop         (w_ld_pop),
        .o_head_waddr  (w_head_waddr),
        .o_head_wdata  (w_head_wdata),
        .o_full        (w_full),
        .o_count       (w_count),
        .o_entry_waddr (w_entry_waddr),
        .o_entry_valid (w_entry_valid)
    );

    // No look-ahead on a same-cycle pop: a full FIFO refuses loads.
    assign w_ld_ready = !rst && !w_full;
    assign w_ld_push  = bus.ld_valid && w_ld_ready;

    // Any older queued load to the same register must land first.
    always_comb begin
        w_fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && (w_entry_waddr[i] == bus.alu_waddr)) begin
                w_fifo_hit = 1'b1;
            end
        end
    end

    // A load arriving this cycle counts as older than the ALU result.
    assign w_arrival_hit = w_ld_push && (bus.ld_waddr == bus.alu_waddr);

    // x0 is never written, so it cannot create a hazard. A full FIFO still
    // blocks the ALU so that the head is guaranteed a pop slot.
    assign w_alu_block = w_full
                      || ((bus.alu_waddr != '0) && (w_fifo_hit || w_arrival_hit));
    assign w_alu_ready = !rst && !w_alu_block;
    assign w_alu_fire  = bus.alu_valid && w_alu_ready;
    assign w_ld_pop    = !rst && !w_alu_fire && (w_count != '0);

    always_comb begin
        w_grant = GNT_IDLE;
        if (w_alu_fire) begin
            w_grant = GNT_ALU;
        end else if (w_ld_pop) begin
            w_grant = GNT_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= WRITE_DISABLE;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (w_grant)
                GNT_ALU: begin
                    r_we    <= (bus.alu_waddr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
                    r_waddr <= bus.alu_waddr;
                    r_wdata <= bus.alu_wdata;
                end
                GNT_LD: begin
                    r_we    <= (w_head_waddr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
                    r_waddr <= w_head_waddr;
                    r_wdata <= w_head_wdata;
                end
                default: begin
                    r_we <= WRITE_DISABLE;
                end
            endcase
        end
    end

    assign bus.alu_ready  = w_alu_ready;
    assign bus.ld_ready   = w_ld_ready;
    assign bus.we         = r_we;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = r_wdata;
    assign bus.ld_pending = (w_count != '0);

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_write_arbiter
// Purpose : Directed, table-driven checks of the write-back arbiter plus a
//           hand-written write-after-write ordering sequence.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_write_arbiter;

    localparam int c_AW = 5;
    localparam int c_DW = 32;

    logic clk;
    logic rst;

    wb_write_arbiter_if #(.AW(c_AW), .DW(c_DW)) bus ();

    wb_write_arbiter #(
        .DEPTH (4),
        .AW    (c_AW),
        .DW    (c_DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_ar;   // alu_ready before the edge
        logic        e_lr;   // ld_ready before the edge
        logic        e_we;   // after the edge
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_p;    // ld_pending after the edge
    } vec_t;

    vec_t vq[$];
    int   tests;
    int   fails;

    function automatic vec_t mk(
        input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic ar, input logic lr,
        input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic p);
        vec_t v;
        v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv;  v.la = la; v.ld = ld;
        v.e_ar = ar; v.e_lr = lr;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_p = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        rst           = r;
        bus.alu_valid = av;
        bus.alu_waddr = aa;
        bus.alu_wdata = ad;
        bus.ld_valid  = lv;
        bus.ld_waddr  = la;
        bus.ld_wdata  = ld;
    endtask

    logic [36:0] obs[$];
    logic        accepted;
    logic        ar_s;

    initial begin
        tests = 0;
        fails = 0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        //       rst av aa  ad          lv la  ld          ar lr  we wa  wd          p
        // reset with both sources requesting
        vq.push_back(mk(1, 1, 5,  32'h1,      1, 9,  32'h2,      0, 0, 0, 0,  32'h0,      0));
        vq.push_back(mk(1, 0, 0,  32'h0,      0, 0,  32'h0,      0, 0, 0, 0,  32'h0,      0));
        // ALU only, back-to-back
        vq.push_back(mk(0, 1, 5,  32'h1234,   0, 0,  32'h0,      1, 1, 1, 5,  32'h1234,   0));
        vq.push_back(mk(0, 1, 6,  32'h6666,   0, 0,  32'h0,      1, 1, 1, 6,  32'h6666,   0));
        vq.push_back(mk(0, 1, 7,  32'h7777,   0, 0,  32'h0,      1, 1, 1, 7,  32'h7777,   0));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 7,  32'h7777,   0));
        // load into an empty FIFO: push, then pop
        vq.push_back(mk(0, 0, 0,  32'h0,      1, 9,  32'hDEAD,   1, 1, 0, 7,  32'h7777,   1));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 9,  32'hDEAD,   0));
        // WAW on x3: load first, ALU held off until it drains
        vq.push_back(mk(0, 1, 3,  32'hBBBB,   1, 3,  32'hAAAA,   0, 1, 0, 9,  32'hDEAD,   1));
        vq.push_back(mk(0, 1, 3,  32'hBBBB,   0, 0,  32'h0,      0, 1, 1, 3,  32'hAAAA,   0));
        vq.push_back(mk(0, 1, 3,  32'hBBBB,   0, 0,  32'h0,      1, 1, 1, 3,  32'hBBBB,   0));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 3,  32'hBBBB,   0));
        // fill the FIFO while the ALU streams to distinct registers
        vq.push_back(mk(0, 1, 10, 32'hA010,   1, 20, 32'h5020,   1, 1, 1, 10, 32'hA010,   1));
        vq.push_back(mk(0, 1, 11, 32'hA011,   1, 21, 32'h5021,   1, 1, 1, 11, 32'hA011,   1));
        vq.push_back(mk(0, 1, 12, 32'hA012,   1, 22, 32'h5022,   1, 1, 1, 12, 32'hA012,   1));
        vq.push_back(mk(0, 1, 13, 32'hA013,   1, 23, 32'h5023,   1, 1, 1, 13, 32'hA013,   1));
        vq.push_back(mk(0, 1, 14, 32'hA014,   1, 24, 32'h5024,   0, 0, 1, 20, 32'h5020,   1));
        vq.push_back(mk(0, 1, 14, 32'hA014,   1, 24, 32'h5024,   1, 1, 1, 14, 32'hA014,   1));
        vq.push_back(mk(0, 1, 15, 32'hA015,   0, 0,  32'h0,      0, 0, 1, 21, 32'h5021,   1));
        vq.push_back(mk(0, 1, 15, 32'hA015,   0, 0,  32'h0,      1, 1, 1, 15, 32'hA015,   1));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 22, 32'h5022,   1));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 23, 32'h5023,   1));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 24, 32'h5024,   0));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 24, 32'h5024,   0));
        // x0 write: handshake completes, no write strobe
        vq.push_back(mk(0, 1, 0,  32'hFFFF,   0, 0,  32'h0,      1, 1, 0, 0,  32'hFFFF,   0));
        // queue three loads, then reset mid-operation
        vq.push_back(mk(0, 1, 8,  32'hA008,   1, 1,  32'h5001,   1, 1, 1, 8,  32'hA008,   1));
        vq.push_back(mk(0, 1, 9,  32'hA009,   1, 2,  32'h5002,   1, 1, 1, 9,  32'hA009,   1));
        vq.push_back(mk(0, 1, 10, 32'hA00A,   1, 4,  32'h5004,   1, 1, 1, 10, 32'hA00A,   1));
        vq.push_back(mk(1, 1, 11, 32'hA00B,   1, 5,  32'h5005,   0, 0, 0, 0,  32'h0,      0));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 0,  32'h0,      0));
        vq.push_back(mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 0,  32'h0,      0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].av, vq[i].aa, vq[i].ad, vq[i].lv, vq[i].la, vq[i].ld);
            #1;
            check($sformatf("row%0d alu_ready", i), 32'(bus.alu_ready), 32'(vq[i].e_ar));
            check($sformatf("row%0d ld_ready", i),  32'(bus.ld_ready),  32'(vq[i].e_lr));
            @(posedge clk);
            #1;
            check($sformatf("row%0d we", i),         32'(bus.we),         32'(vq[i].e_we));
            check($sformatf("row%0d waddr", i),      32'(bus.waddr),      32'(vq[i].e_wa));
            check($sformatf("row%0d wdata", i),      bus.wdata,           vq[i].e_wd);
            check($sformatf("row%0d ld_pending", i), 32'(bus.ld_pending), 32'(vq[i].e_p));
        end

        // Same-cycle load and ALU to x12: load must land first, ALU waits
        // (bounded) for its ready.
        accepted = 1'b0;
        drive(1'b0, 1'b1, 5'd12, 32'h2222, 1'b1, 5'd12, 32'h1111);
        for (int c = 0; c < 8; c++) begin
            #1;
            ar_s = bus.alu_ready && bus.alu_valid;
            @(posedge clk);
            #1;
            if (bus.we) obs.push_back({bus.waddr, bus.wdata});
            bus.ld_valid = 1'b0;
            if (ar_s) begin
                accepted      = 1'b1;
                bus.alu_valid = 1'b0;
            end
        end
        check("waw alu accepted within bound", 32'(accepted), 32'd1);
        check("waw write count", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            check("waw first write", 32'(obs[0]), 32'({5'd12, 32'h1111}));
            check("waw second write", 32'(obs[1]), 32'({5'd12, 32'h2222}));
            check("waw first addr", 32'(obs[0][36:32]), 32'd12);
            check("waw second addr", 32'(obs[1][36:32]), 32'd12);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_write_arbiter
`default_nettype wire
